mouse_cfg_seq: RTL and testbench

Configuration sequencer for the PS/2 mouse controller's load interface (value/setx/sety/setmax_x/setmax_y).
- After reset, programs cursor limits and the start position into the mouse controller.
- Re-runs all or part of that programming on request from game logic: resolution change, recenter, full restart.
- Sits in the 100 MHz mouse domain, beside the mouse controller; its outputs drive that controller's load ports directly.

---
 rtl/mouse_cfg_seq.sv | 216 +++++++++++++++++++++
 tb/tb_mouse_cfg_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_cfg_seq.sv
// ----------------------------------------------------------------------------
// mouse_cfg_seq
//   Configuration sequencer for the PS/2 mouse controller load interface.
//   After reset it programs the cursor limits and the start position. Later it
//   re-runs all or part of that programming on request: full restart,
//   resolution change (resize) or recenter.
//
//   Build option: define MOUSE_CFG_AUTOCENTER_EN to make every resize also
//   rewrite the position. Resize and recenter then target the middle of the
//   current limits (lim >> 1). The full sequence still uses INIT_X/INIT_Y,
//   clamped to the limits.
//
// Ports
//   clk, rst_n            100 MHz mouse-domain clock, async active-low reset
//   start_cfg_i           pulse: rerun the full sequence
//   res_valid_i           pulse: new limits on max_x_in_i / max_y_in_i
//   max_x_in_i/max_y_in_i new limits, taken when res_valid_i = 1
//   recenter_req_i        level request, rising edge starts a recenter
//   recenter_ack_o        one-cycle pulse when a recenter completes
//   value_o               load value to the mouse controller
//   setmax_x_o/setmax_y_o one-cycle load strobes for the limits
//   setx_o/sety_o         one-cycle load strobes for the position
//   busy_o                high while any sequence runs
//   cfg_done_o            set after the first full sequence, cleared by reset
// ----------------------------------------------------------------------------
module mouse_cfg_seq #(
    parameter logic [11:0] MAX_X  = 12'd1023,
    parameter logic [11:0] MAX_Y  = 12'd767,
    parameter logic [11:0] INIT_X = 12'd512,
    parameter logic [11:0] INIT_Y = 12'd384,
    parameter int unsigned GAP    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_cfg_i,
    input  logic        res_valid_i,
    input  logic [11:0] max_x_in_i,
    input  logic [11:0] max_y_in_i,
    input  logic        recenter_req_i,
    output logic        recenter_ack_o,
    output logic [11:0] value_o,
    output logic        setmax_x_o,
    output logic        setmax_y_o,
    output logic        setx_o,
    output logic        sety_o,
    output logic        busy_o,
    output logic        cfg_done_o
);

`ifdef MOUSE_CFG_AUTOCENTER_EN
    localparam bit AUTOCENTER = 1'b1;
`else
    localparam bit AUTOCENTER = 1'b0;
`endif

    localparam logic [3:0] GAP_CNT = 4'(GAP);

    typedef enum logic [2:0] {
        S_IDLE, S_W_MAXX, S_W_MAXY, S_W_X, S_W_Y, S_GAP_WAIT
    } state_e;

    state_e      state_q, ret_q;
    logic [3:0]  gap_cnt_q;
    logic [11:0] lim_x_q, lim_y_q, lim_x_d, lim_y_d;
    logic [11:0] clamp_x, clamp_y, half_x, half_y, tgt_x, tgt_y;
    logic        boot_q, start_pend_q, res_pend_q, rec_pend_q, rec_prev_q;
    logic        ack_owed_q, full_q, center_q, do_pos_q, rec_edge;
    logic [11:0] value_q;
    logic        setmax_x_q, setmax_y_q, setx_q, sety_q;
    logic        busy_q, cfg_done_q, recenter_ack_q;

    // A res_valid pulse takes effect in its own cycle. Any write launched in
    // that cycle already uses the new limits.
    always_comb begin
        lim_x_d  = res_valid_i ? max_x_in_i : lim_x_q;
        lim_y_d  = res_valid_i ? max_y_in_i : lim_y_q;
        clamp_x  = (lim_x_d < INIT_X) ? lim_x_d : INIT_X;
        clamp_y  = (lim_y_d < INIT_Y) ? lim_y_d : INIT_Y;
        half_x   = lim_x_d >> 1;
        half_y   = lim_y_d >> 1;
        tgt_x    = center_q ? half_x : clamp_x;
        tgt_y    = center_q ? half_y : clamp_y;
        rec_edge = recenter_req_i & ~rec_prev_q;
    end

    // NOTE: every register in this block is assigned with <= only. The
    // request flags below the case statement are set after it, so a new
    // request in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ret_q          <= S_IDLE;
            gap_cnt_q      <= '0;
            lim_x_q        <= MAX_X;
            lim_y_q        <= MAX_Y;
            boot_q         <= 1'b1;   // launches the automatic sequence after release
            start_pend_q   <= 1'b0;
            res_pend_q     <= 1'b0;
            rec_pend_q     <= 1'b0;
            rec_prev_q     <= 1'b0;
            ack_owed_q     <= 1'b0;
            full_q         <= 1'b0;
            center_q       <= 1'b0;
            do_pos_q       <= 1'b0;
            value_q        <= '0;
            setmax_x_q     <= 1'b0;
            setmax_y_q     <= 1'b0;
            setx_q         <= 1'b0;
            sety_q         <= 1'b0;
            busy_q         <= 1'b0;
            cfg_done_q     <= 1'b0;
            recenter_ack_q <= 1'b0;
        end else begin
            setmax_x_q     <= 1'b0;
            setmax_y_q     <= 1'b0;
            setx_q         <= 1'b0;
            sety_q         <= 1'b0;
            recenter_ack_q <= 1'b0;
            lim_x_q        <= lim_x_d;
            lim_y_q        <= lim_y_d;
            rec_prev_q     <= recenter_req_i;

            case (state_q)
                S_IDLE: begin
                    if (boot_q || start_pend_q) begin
                        // A full run absorbs every other pending request. A
                        // swallowed recenter is still acknowledged at the end.
                        boot_q       <= 1'b0;
                        start_pend_q <= 1'b0;
                        res_pend_q   <= 1'b0;
                        rec_pend_q   <= 1'b0;
                        ack_owed_q   <= rec_pend_q;
                        full_q       <= 1'b1;
                        center_q     <= 1'b0;
                        do_pos_q     <= 1'b1;
                        state_q      <= S_W_MAXX;
                        value_q      <= lim_x_d;
                        setmax_x_q   <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (res_pend_q) begin
                        res_pend_q   <= 1'b0;
                        ack_owed_q   <= 1'b0;
                        full_q       <= 1'b0;
                        center_q     <= AUTOCENTER;
                        do_pos_q     <= AUTOCENTER || (INIT_X > lim_x_d) || (INIT_Y > lim_y_d);
                        state_q      <= S_W_MAXX;
                        value_q      <= lim_x_d;
                        setmax_x_q   <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (rec_pend_q) begin
                        rec_pend_q   <= 1'b0;
                        ack_owed_q   <= 1'b1;
                        full_q       <= 1'b0;
                        center_q     <= AUTOCENTER;
                        state_q      <= S_W_X;
                        value_q      <= AUTOCENTER ? half_x : clamp_x;
                        setx_q       <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                S_W_MAXX: begin
                    state_q   <= S_GAP_WAIT;
                    gap_cnt_q <= GAP_CNT;
                    ret_q     <= S_W_MAXY;
                end
                S_W_MAXY: begin
                    state_q   <= S_GAP_WAIT;
                    gap_cnt_q <= GAP_CNT;
                    ret_q     <= do_pos_q ? S_W_X : S_IDLE;
                end
                S_W_X: begin
                    state_q   <= S_GAP_WAIT;
                    gap_cnt_q <= GAP_CNT;
                    ret_q     <= S_W_Y;
                end
                S_W_Y: begin
                    state_q   <= S_GAP_WAIT;
                    gap_cnt_q <= GAP_CNT;
                    ret_q     <= S_IDLE;
                end
                S_GAP_WAIT: begin
                    if (gap_cnt_q <= 4'd1) begin
                        state_q <= ret_q;
                        case (ret_q)
                            S_W_MAXY: begin value_q <= lim_y_d; setmax_y_q <= 1'b1; end
                            S_W_X:    begin value_q <= tgt_x;   setx_q     <= 1'b1; end
                            S_W_Y:    begin value_q <= tgt_y;   sety_q     <= 1'b1; end
                            default: begin
                                busy_q         <= 1'b0;
                                recenter_ack_q <= ack_owed_q;
                                if (full_q) cfg_done_q <= 1'b1;
                            end
                        endcase
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (start_cfg_i) start_pend_q <= 1'b1;
            if (res_valid_i) res_pend_q   <= 1'b1;
            if (rec_edge)    rec_pend_q   <= 1'b1;
        end
    end

    assign value_o        = value_q;
    assign setmax_x_o     = setmax_x_q;
    assign setmax_y_o     = setmax_y_q;
    assign setx_o         = setx_q;
    assign sety_o         = sety_q;
    assign busy_o         = busy_q;
    assign cfg_done_o     = cfg_done_q;
    assign recenter_ack_o = recenter_ack_q;

endmodule

// File: tb/tb_mouse_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_mouse_cfg_seq
//   Self-checking bench for mouse_cfg_seq. A queue-based reference model runs
//   every cycle beside the DUT. Table-driven and hand-written sequences cover
//   the documented scenarios. A random phase follows them.
// ----------------------------------------------------------------------------
module tb_mouse_cfg_seq;

    localparam logic [11:0] MAX_X  = 12'd1023;
    localparam logic [11:0] MAX_Y  = 12'd767;
    localparam logic [11:0] INIT_X = 12'd512;
    localparam logic [11:0] INIT_Y = 12'd384;
    localparam int          GAP    = 4;
`ifdef MOUSE_CFG_AUTOCENTER_EN
    localparam bit AUTOC = 1'b1;
`else
    localparam bit AUTOC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_cfg_i = 1'b0, res_valid_i = 1'b0, recenter_req_i = 1'b0;
    logic [11:0] max_x_in_i = '0, max_y_in_i = '0;
    logic        recenter_ack_o, setmax_x_o, setmax_y_o, setx_o, sety_o, busy_o, cfg_done_o;
    logic [11:0] value_o;

    mouse_cfg_seq #(.MAX_X(MAX_X), .MAX_Y(MAX_Y), .INIT_X(INIT_X), .INIT_Y(INIT_Y), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .start_cfg_i(start_cfg_i), .res_valid_i(res_valid_i),
        .max_x_in_i(max_x_in_i), .max_y_in_i(max_y_in_i), .recenter_req_i(recenter_req_i),
        .recenter_ack_o(recenter_ack_o), .value_o(value_o), .setmax_x_o(setmax_x_o),
        .setmax_y_o(setmax_y_o), .setx_o(setx_o), .sety_o(sety_o), .busy_o(busy_o),
        .cfg_done_o(cfg_done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each sequence is expanded into a per-cycle plan: k = 1..4 is a write
    // (setmax_x, setmax_y, setx, sety), 0 is a gap cycle, 5 is the return to
    // idle. An empty plan means the sequencer is idle.
    int          m_plan[$];
    bit          m_boot, m_sp, m_rp, m_cp, m_ack_owed, m_full, m_center, m_rec_prev;
    logic [11:0] m_lx, m_ly, m_val;
    logic [3:0]  m_strb;
    bit          m_busy, m_done, m_ack;

    task automatic plan_write(input int k);
        m_plan.push_back(k);
        for (int i = 0; i < GAP; i++) m_plan.push_back(0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot = 1; m_sp = 0; m_rp = 0; m_cp = 0; m_ack_owed = 0;
            m_full = 0; m_center = 0; m_rec_prev = 0;
            m_lx = MAX_X; m_ly = MAX_Y; m_plan.delete();
            m_val = '0; m_strb = '0; m_busy = 0; m_done = 0; m_ack = 0;
        end else begin : step
            logic [11:0] ex, ey;
            int k;
            ex = res_valid_i ? max_x_in_i : m_lx;
            ey = res_valid_i ? max_y_in_i : m_ly;
            if (m_plan.size() == 0) begin
                if (m_boot || m_sp) begin
                    m_ack_owed = m_cp; m_boot = 0; m_sp = 0; m_rp = 0; m_cp = 0;
                    m_full = 1; m_center = 0;
                    for (int w = 1; w <= 4; w++) plan_write(w);
                    m_plan.push_back(5);
                end else if (m_rp) begin
                    m_rp = 0; m_ack_owed = 0; m_full = 0; m_center = AUTOC;
                    plan_write(1); plan_write(2);
                    if (AUTOC || INIT_X > ex || INIT_Y > ey) begin plan_write(3); plan_write(4); end
                    m_plan.push_back(5);
                end else if (m_cp) begin
                    m_cp = 0; m_ack_owed = 1; m_full = 0; m_center = AUTOC;
                    plan_write(3); plan_write(4);
                    m_plan.push_back(5);
                end
            end
            if (start_cfg_i) m_sp = 1;
            if (res_valid_i) begin m_rp = 1; m_lx = max_x_in_i; m_ly = max_y_in_i; end
            if (recenter_req_i && !m_rec_prev) m_cp = 1;
            m_rec_prev = recenter_req_i;

            m_strb = '0; m_ack = 0; m_busy = 0;
            if (m_plan.size() > 0) begin
                k = m_plan.pop_front();
                case (k)
                    0: m_busy = 1;
                    1: begin m_busy = 1; m_strb = 4'b1000; m_val = ex; end
                    2: begin m_busy = 1; m_strb = 4'b0100; m_val = ey; end
                    3: begin m_busy = 1; m_strb = 4'b0010;
                             m_val = m_center ? (ex >> 1) : ((ex < INIT_X) ? ex : INIT_X); end
                    4: begin m_busy = 1; m_strb = 4'b0001;
                             m_val = m_center ? (ey >> 1) : ((ey < INIT_Y) ? ey : INIT_Y); end
                    default: begin m_ack = m_ack_owed; if (m_full) m_done = 1; end
                endcase
            end
        end
    end

    bit mon_en = 0;
    always @(negedge clk) begin
        if (mon_en)
            check("model_cycle",
                  {13'd0, value_o, setmax_x_o, setmax_y_o, setx_o, sety_o, busy_o, cfg_done_o, recenter_ack_o},
                  {13'd0, m_val, m_strb, m_busy, m_done, m_ack});
    end

    // ---------------- observation helpers ----------------
    int          obs_k[$], obs_c[$];
    logic [11:0] obs_v[$];
    int          exp_k[$];
    logic [11:0] exp_v[$];
    int          ack_n, ack_cyc;

    task automatic observe(input int n);
        obs_k.delete(); obs_c.delete(); obs_v.delete(); ack_n = 0; ack_cyc = -1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (setmax_x_o) begin obs_k.push_back(1); obs_v.push_back(value_o); obs_c.push_back(c); end
            if (setmax_y_o) begin obs_k.push_back(2); obs_v.push_back(value_o); obs_c.push_back(c); end
            if (setx_o)     begin obs_k.push_back(3); obs_v.push_back(value_o); obs_c.push_back(c); end
            if (sety_o)     begin obs_k.push_back(4); obs_v.push_back(value_o); obs_c.push_back(c); end
            if (recenter_ack_o) begin ack_n++; ack_cyc = c; end
        end
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, obs_k.size(), exp_k.size());
        for (int i = 0; i < exp_k.size() && i < obs_k.size(); i++) begin
            check($sformatf("%s_kind%0d", tag, i), obs_k[i], exp_k[i]);
            check($sformatf("%s_val%0d", tag, i), obs_v[i], exp_v[i]);
        end
    endtask

    task automatic set_exp(input int n, input int k0, k1, k2, k3,
                           input logic [11:0] v0, v1, v2, v3);
        int ks[4]; logic [11:0] vs[4];
        ks = '{k0, k1, k2, k3}; vs = '{v0, v1, v2, v3};
        exp_k.delete(); exp_v.delete();
        for (int i = 0; i < n; i++) begin exp_k.push_back(ks[i]); exp_v.push_back(vs[i]); end
    endtask

    // ---------------- boot-sequence vector table ----------------
    typedef struct {
        logic        start_cfg;   // input applied during the cycle
        logic [3:0]  strb;        // {setmax_x, setmax_y, setx, sety}
        logic [11:0] value;
        logic        busy;
        logic        done;
    } vec_t;
    vec_t boot_vec[1:22];

    initial begin
        for (int c = 1; c <= 22; c++) begin
            boot_vec[c].start_cfg = 1'b0;
            boot_vec[c].strb      = 4'b0000;
            boot_vec[c].busy      = (c <= 20);
            boot_vec[c].done      = (c >= 21);
            if (c <= 5)       boot_vec[c].value = 12'd1023;
            else if (c <= 10) boot_vec[c].value = 12'd767;
            else if (c <= 15) boot_vec[c].value = 12'd512;
            else              boot_vec[c].value = 12'd384;
        end
        boot_vec[1].strb  = 4'b1000;
        boot_vec[6].strb  = 4'b0100;
        boot_vec[11].strb = 4'b0010;
        boot_vec[16].strb = 4'b0001;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1;
        check("reset_outputs",
              {value_o, setmax_x_o, setmax_y_o, setx_o, sety_o, busy_o, cfg_done_o, recenter_ack_o}, 19'd0);
        rst_n = 1'b1;

        // 1) automatic sequence after reset
        for (int c = 1; c <= 22; c++) begin
            start_cfg_i = boot_vec[c].start_cfg;
            @(negedge clk);
            check($sformatf("boot_c%0d", c),
                  {setmax_x_o, setmax_y_o, setx_o, sety_o, value_o, busy_o, cfg_done_o},
                  {boot_vec[c].strb, boot_vec[c].value, boot_vec[c].busy, boot_vec[c].done});
        end

        // 2) recenter held high: one sequence, one ack, no retrigger
        recenter_req_i = 1'b1;
        observe(40);
        recenter_req_i = 1'b0;
        if (AUTOC) set_exp(2, 3, 4, 0, 0, 12'd511, 12'd383, 0, 0);
        else       set_exp(2, 3, 4, 0, 0, 12'd512, 12'd384, 0, 0);
        check_seq("recenter");
        check("recenter_ack_count", ack_n, 1);
        check("recenter_ack_cycle", ack_cyc, 12);
        if (obs_c.size() == 2) check("recenter_setx_cycle", obs_c[0], 2);

        // 3) full sequence with two more starts and a recenter queued behind it
        fork
            begin
                start_cfg_i = 1'b1; @(negedge clk); start_cfg_i = 1'b0;
                repeat (4) @(negedge clk);
                start_cfg_i = 1'b1; @(negedge clk); start_cfg_i = 1'b0;
                repeat (3) @(negedge clk);
                start_cfg_i = 1'b1; recenter_req_i = 1'b1; @(negedge clk); start_cfg_i = 1'b0;
            end
            observe(60);
        join
        recenter_req_i = 1'b0;
        exp_k.delete(); exp_v.delete();
        for (int r = 0; r < 2; r++) begin
            exp_k.push_back(1); exp_v.push_back(12'd1023);
            exp_k.push_back(2); exp_v.push_back(12'd767);
            exp_k.push_back(3); exp_v.push_back(12'd512);
            exp_k.push_back(4); exp_v.push_back(12'd384);
        end
        check_seq("collapse");
        check("collapse_ack_count", ack_n, 1);
        check("collapse_ack_cycle", ack_cyc, 43);

        // 4) resize to 639x479
        fork
            begin
                res_valid_i = 1'b1; max_x_in_i = 12'd639; max_y_in_i = 12'd479;
                @(negedge clk); res_valid_i = 1'b0;
            end
            observe(40);
        join
        if (AUTOC) set_exp(4, 1, 2, 3, 4, 12'd639, 12'd479, 12'd319, 12'd239);
        else       set_exp(2, 1, 2, 0, 0, 12'd639, 12'd479, 0, 0);
        check_seq("resize_639");
        check("resize_639_noack", ack_n, 0);

        // 5) resize to 300x200: position exceeds the new limits
        fork
            begin
                res_valid_i = 1'b1; max_x_in_i = 12'd300; max_y_in_i = 12'd200;
                @(negedge clk); res_valid_i = 1'b0;
            end
            observe(40);
        join
        if (AUTOC) set_exp(4, 1, 2, 3, 4, 12'd300, 12'd200, 12'd150, 12'd100);
        else       set_exp(4, 1, 2, 3, 4, 12'd300, 12'd200, 12'd300, 12'd200);
        check_seq("resize_300");

        // 6) reset in the gap after setmax_y
        begin : rst_mid
            bit found;
            found = 0;
            start_cfg_i = 1'b1; @(negedge clk); start_cfg_i = 1'b0;
            for (int c = 0; c < 60 && !found; c++) begin
                @(negedge clk);
                if (setmax_y_o) found = 1;
            end
            check("rst_wait_setmax_y", found, 1);
            repeat (2) @(negedge clk);
            @(posedge clk); #2 rst_n = 1'b0;
            #1 check("rst_mid_outputs",
                     {value_o, setmax_x_o, setmax_y_o, setx_o, sety_o, busy_o, cfg_done_o, recenter_ack_o},
                     19'd0);
            @(negedge clk); rst_n = 1'b1;
            observe(25);
            set_exp(4, 1, 2, 3, 4, 12'd1023, 12'd767, 12'd512, 12'd384);
            check_seq("rst_restart");
            if (obs_c.size() > 0) check("rst_restart_first_cycle", obs_c[0], 1);
            check("rst_restart_done", cfg_done_o, 1);
        end

        // 7) random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start_cfg_i = ($urandom % 40) == 0;
            res_valid_i = ($urandom % 30) == 0;
            if ($urandom % 2) begin
                max_x_in_i = 12'($urandom_range(0, 4095));
                max_y_in_i = 12'($urandom_range(0, 4095));
            end else begin
                max_x_in_i = 12'($urandom_range(300, 1100));
                max_y_in_i = 12'($urandom_range(200, 800));
            end
            if (($urandom % 25) == 0) recenter_req_i = ~recenter_req_i;
        end
        @(negedge clk);
        start_cfg_i = 1'b0; res_valid_i = 1'b0; recenter_req_i = 1'b0;
        repeat (150) @(negedge clk);
        check("final_idle", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
